// File: rtl/fifo_pkg.sv
// Shared definitions for the async-compare FIFO (read side, write side, comparator).
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   FIFO_ADDRSIZE / FIFO_DSIZE : default pointer and data widths shared by all FIFO blocks
//   rd_state_t                 : read-side output-stage state
//   bin2gray                   : binary to reflected Gray conversion

package fifo_pkg;

    // Default pointer width (depth = 2**FIFO_ADDRSIZE) and data word width.
    localparam int FIFO_ADDRSIZE = 4;
    localparam int FIFO_DSIZE    = 8;

    // Read output stage:
    //   RD_IDLE : nothing held, nothing in flight
    //   RD_WAIT : RAM read issued last cycle, data arrives on the next edge
    //   RD_FULL : a word is presented to the consumer
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_FULL = 2'd2
    } rd_state_t;

    // Generic 32-bit Gray conversion; callers truncate to their pointer width.
    // Truncation is safe because the MSBs above the pointer width are zero.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer into the destination clock domain.
// Latency: STAGES clock edges from a stable input to the output.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, loads RST_VAL into every stage
//   d   : asynchronous input
//   q   : synchronized output (last stage)
//
// STAGES must be at least 2. RST_VAL lets the same block serve active-low
// status flags on either side of the FIFO (e.g. aempty_n, afull_n).

module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= {STAGES{RST_VAL}};
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async-compare FIFO: owns the read pointer and a FWFT output stage.
// Latency: a RAM read issued in cycle t shows up as rvalid/rdata in cycle t+2.
// Backpressure: rready low holds rdata/rvalid stable and blocks further reads.
//
// Ports:
//   rclk      : read-domain clock
//   rrst      : synchronous active-high reset
//   aempty_n  : asynchronous empty from the pointer comparator (active-low, unsynchronized)
//   rptr      : registered Gray read pointer, to the comparator
//   raddr     : binary RAM read address (current read pointer)
//   ren       : RAM read enable (combinational)
//   rdata_mem : RAM read data, valid one cycle after ren
//   rdata     : word presented to the consumer
//   rvalid    : rdata valid
//   rready    : consumer accepts rdata
//   rempty    : synchronized empty status, active-high

module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = FIFO_ADDRSIZE,
    parameter int DSIZE       = FIFO_DSIZE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                aempty_n,
    output logic [ADDRSIZE-1:0] rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                ren,
    input  logic [DSIZE-1:0]    rdata_mem,
    output logic [DSIZE-1:0]    rdata,
    output logic                rvalid,
    input  logic                rready,
    output logic                rempty
);

    // The holdoff window must span the comparator reacting to the new rptr plus
    // the synchronizer depth, so a not-empty that predates the last pop is never
    // trusted. Reloaded to SYNC_STAGES+1 and counted down to zero.
    localparam int HOLD_W = $clog2(SYNC_STAGES + 2);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(SYNC_STAGES + 1);

    // ------------------------------------------------------------------
    // Empty flag synchronizer (reset value 0 => rempty=1 out of reset)
    // ------------------------------------------------------------------
    logic aempty_n_sync;

    sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_empty_sync (
        .clk (rclk),
        .rst (rrst),
        .d   (aempty_n),
        .q   (aempty_n_sync)
    );

    assign rempty = ~aempty_n_sync;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rd_state_t           state;
    rd_state_t           state_nxt;
    logic [ADDRSIZE-1:0] rbin;
    logic [ADDRSIZE-1:0] rbin_nxt;
    logic [ADDRSIZE-1:0] rgray_nxt;
    logic [HOLD_W-1:0]   holdoff;
    logic                can_read;
    logic                load_word;
    logic                drop_word;

    // Pointer arithmetic. The binary pointer wraps naturally at 2**ADDRSIZE,
    // and the Gray image of the wrapped value keeps the one-bit-change property
    // across the all-ones -> zero transition.
    assign rbin_nxt  = rbin + 1'b1;
    assign rgray_nxt = ADDRSIZE'(bin2gray(32'(rbin_nxt)));

    assign raddr = rbin;
    assign ren   = can_read;

    // ------------------------------------------------------------------
    // Next state / read decision
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        can_read  = 1'b0;
        load_word = 1'b0;
        drop_word = 1'b0;

        // A read is allowed when the stage is free, or is being emptied this
        // cycle by the consumer, and the empty status is trustworthy.
        if (!rempty && (holdoff == '0)) begin
            if (state == RD_IDLE) begin
                can_read = 1'b1;
            end else if ((state == RD_FULL) && rready) begin
                can_read = 1'b1;
            end
        end

        case (state)
            RD_IDLE: begin
                if (can_read) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // RAM data for the read issued last cycle is on rdata_mem now.
                load_word = 1'b1;
                state_nxt = RD_FULL;
            end
            RD_FULL: begin
                if (rready) begin
                    drop_word = 1'b1;
                    state_nxt = can_read ? RD_WAIT : RD_IDLE;
                end
            end
            default: begin
                state_nxt = RD_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state   <= RD_IDLE;
            rbin    <= '0;
            rptr    <= '0;
            holdoff <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
        end else begin
            state <= state_nxt;

            // Pointer advance happens only on a RAM read.
            if (can_read) begin
                rbin    <= rbin_nxt;
                rptr    <= rgray_nxt;
                holdoff <= HOLD_RELOAD;
            end else if (holdoff != '0) begin
                holdoff <= holdoff - 1'b1;
            end

            // Output stage: load wins over drop; both never occur together
            // because they belong to different states.
            if (load_word) begin
                rdata  <= rdata_mem;
                rvalid <= 1'b1;
            end else if (drop_word) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios plus randomized traffic
// against a queue-based model of FIFO contents and consumer deliveries.
// The write side and comparator are modelled as "words written minus words read".

module tb_fifo_rd_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int SS    = 2;
    localparam int DEPTH = 1 << AW;

    logic          rclk;
    logic          rrst;
    logic          aempty_n;
    logic [AW-1:0] rptr;
    logic [AW-1:0] raddr;
    logic          ren;
    logic [DW-1:0] rdata_mem;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          rempty;

    fifo_rd_ctrl #(
        .ADDRSIZE    (AW),
        .DSIZE       (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .aempty_n  (aempty_n),
        .rptr      (rptr),
        .raddr     (raddr),
        .ren       (ren),
        .rdata_mem (rdata_mem),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .rempty    (rempty)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Registered-read RAM model.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge rclk) begin
        if (ren) rdata_mem <= mem[raddr];
    end

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int            n_chk;
    int            n_fail;
    int            pushed;       // words written so far
    int            rd;           // words read from RAM so far
    logic [DW-1:0] hist [4096];  // every word written, by absolute index
    logic [DW-1:0] pend [$];     // words read from RAM, awaiting delivery
    bit            ae_force_low; // comparator overridden to report empty
    int            cyc;
    int            last_ren_cyc;
    int            last_gap;
    int            ren_cnt;
    int            hs_cnt;
    bit            p_stall;
    logic [DW-1:0] p_data;
    logic [AW-1:0] p_rptr;

    // Sampled DUT outputs of the most recent tick.
    logic          s_ren;
    logic [AW-1:0] s_raddr;
    logic          s_rvalid;
    logic [DW-1:0] s_rdata;
    logic          s_rempty;
    logic [AW-1:0] s_rptr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] gray_of(input int n);
        logic [AW-1:0] b;
        b = AW'(n % DEPTH);
        return b ^ (b >> 1);
    endfunction

    task automatic upd_ae();
        aempty_n = (!ae_force_low) && (pushed != rd);
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[pushed % DEPTH] = d;
        hist[pushed] = d;
        pushed++;
        upd_ae();
    endtask

    task automatic model_clear();
        pushed  = 0;
        rd      = 0;
        pend.delete();
        p_stall = 1'b0;
        p_rptr  = '0;
    endtask

    // One clock cycle. Entered at a negedge with inputs already set; samples
    // outputs, accounts for what the coming posedge does, returns at the next negedge.
    task automatic tick();
        bit            took;
        logic [DW-1:0] front;
        upd_ae();
        #1;
        s_ren    = ren;
        s_raddr  = raddr;
        s_rvalid = rvalid;
        s_rdata  = rdata;
        s_rempty = rempty;
        s_rptr   = rptr;
        took     = 1'b0;
        if (!rrst) begin
            if (p_stall) begin
                check_eq("stall_valid", s_rvalid, 1);
                check_eq("stall_data", s_rdata, p_data);
            end
            if (s_rvalid && rready) begin
                if (pend.size() == 0) begin
                    check_eq("spurious_valid", 1, 0);
                end else begin
                    front = pend.pop_front();
                    check_eq("pop_data", s_rdata, front);
                end
                hs_cnt++;
            end
            if (s_ren) begin
                check_eq("ren_nonempty", (pushed > rd) ? 1 : 0, 1);
                check_eq("raddr", s_raddr, rd % DEPTH);
                pend.push_back(hist[rd]);
                rd++;
                ren_cnt++;
                last_gap     = cyc - last_ren_cyc;
                last_ren_cyc = cyc;
                took         = 1'b1;
            end
            p_stall = s_rvalid && !rready;
            p_data  = s_rdata;
        end
        @(posedge rclk);
        @(negedge rclk);
        cyc++;
        if (took) begin
            check_eq("rptr_gray", rptr, gray_of(rd));
            check_eq("rptr_onebit", $countones(rptr ^ p_rptr), 1);
            p_rptr = rptr;
        end
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        model_clear();
        tick();
        tick();
        rrst = 1'b0;
    endtask

    initial begin
        int c;
        int held_addr;
        logic [DW-1:0] held_data;
        int hs0;
        int ren0;

        n_chk = 0; n_fail = 0; cyc = 0; ren_cnt = 0; hs_cnt = 0;
        last_ren_cyc = 0; last_gap = 0;
        ae_force_low = 1'b0;
        rrst = 1'b1; rready = 1'b0; aempty_n = 1'b0;
        model_clear();
        @(negedge rclk);
        do_reset();

        // 1) Empty for 20 cycles, with a sub-cycle glitch on aempty_n.
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                aempty_n = 1'b1;
                #2;
                aempty_n = 1'b0;
            end
            tick();
            check_eq("empty_rempty", s_rempty, 1);
            check_eq("empty_ren", s_ren, 0);
            check_eq("empty_rptr", s_rptr, 0);
            check_eq("empty_rvalid", s_rvalid, 0);
        end

        // 2) First-word latency.
        rready = 1'b1;
        push(8'hA5);
        c = 0;
        while (c < 20) begin
            tick();
            if (!s_rempty) break;
            c++;
        end
        check_eq("lat_rempty_fall", c, SS);
        check_eq("lat_ren", s_ren, 1);
        check_eq("lat_raddr", s_raddr, 0);
        check_eq("lat_rptr", rptr, 1);
        tick();
        check_eq("lat_wait_rvalid", s_rvalid, 0);
        tick();
        check_eq("lat_rvalid", s_rvalid, 1);
        check_eq("lat_rdata", s_rdata, 8'hA5);

        // 3) Streaming 17 pops through the wrap, spacing SS+2.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(DW'($urandom));
        rready = 1'b1;
        ren0 = ren_cnt;
        c = 0;
        while ((rd < DEPTH + 1 || pend.size() != 0) && c < 300) begin
            tick();
            if (s_ren && rd == 1) push(DW'($urandom));
            if (s_ren && rd > 1) check_eq("stream_gap", last_gap, SS + 2);
            c++;
        end
        check_eq("stream_done", (c < 300) ? 1 : 0, 1);
        check_eq("stream_ren_cnt", ren_cnt - ren0, DEPTH + 1);
        check_eq("stream_wrap_raddr", raddr, 1);

        // 4) Consumer stall for 10 cycles, then release.
        rready = 1'b0;
        for (int i = 0; i < 3; i++) push(DW'($urandom));
        c = 0;
        while (c < 30) begin
            tick();
            if (s_rvalid) break;
            c++;
        end
        check_eq("stall_got_valid", s_rvalid, 1);
        held_data = s_rdata;
        held_addr = int'(s_raddr);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("stall_no_ren", s_ren, 0);
            check_eq("stall_held", s_rdata, held_data);
            check_eq("stall_raddr", s_raddr, held_addr);
        end
        rready = 1'b1;
        tick();
        check_eq("release_ren", s_ren, 1);

        // 5) Empty reported right after a read: held word delivered, no more reads.
        for (int i = 0; i < 3; i++) push(DW'($urandom));
        c = 0;
        while (c < 30) begin
            tick();
            if (s_ren) break;
            c++;
        end
        check_eq("drop_found_ren", s_ren, 1);
        ae_force_low = 1'b1;
        hs0  = hs_cnt;
        ren0 = ren_cnt;
        for (int i = 0; i < 12; i++) tick();
        check_eq("drop_no_ren", ren_cnt - ren0, 0);
        check_eq("drop_delivered", hs_cnt - hs0, 1);
        check_eq("drop_rempty", s_rempty, 1);
        check_eq("drop_idle_rvalid", s_rvalid, 0);
        ae_force_low = 1'b0;

        // 6) Reset while a RAM read is in flight.
        c = 0;
        while (c < 30) begin
            tick();
            if (s_ren) break;
            c++;
        end
        check_eq("rst_found_ren", s_ren, 1);
        rrst = 1'b1;
        model_clear();
        tick();
        rrst = 1'b0;
        #1;
        check_eq("rst_rvalid", rvalid, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_raddr", raddr, 0);
        check_eq("rst_rptr", rptr, 0);
        check_eq("rst_rempty", rempty, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rst_stays_idle", s_rvalid, 0);
        end

        // 7) Randomized traffic, then drain.
        for (int i = 0; i < 3000; i++) begin
            if ((pushed - rd) < DEPTH && pushed < 4000 && $urandom_range(3) == 0)
                push(DW'($urandom));
            rready = ($urandom_range(9) < 7);
            tick();
        end
        rready = 1'b1;
        c = 0;
        while ((rd != pushed || pend.size() != 0) && c < 2000) begin
            tick();
            c++;
        end
        check_eq("drain_done", (c < 2000) ? 1 : 0, 1);
        check_eq("drain_all_read", rd, pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
